// File: rtl/vend_pkg.sv
// Shared definitions for the vending datapath: credit width, coin
// denominations and the change-dispenser state encoding.
package vend_pkg;

  // Credit width shared with the vending controller.
  localparam int CREDIT_W = 4;

  // Coin denominations, in credit units.
  localparam int DENOM_HI = 2;
  localparam int DENOM_LO = 1;

  // Change-dispenser FSM state encoding.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_PULSE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAULT    = 3'd6
  } disp_state_t;

  // Largest of three cycle counts, used to size a shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter with a zero flag. A load takes priority over
// counting; the counter parks at zero until the next load.
module vend_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load a new interval, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: returns a change amount using greedy selection of
// denomination-2 and denomination-1 coins, confirming each coin via the
// exit sensor and reporting done or a sticky fault.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W_P     = vend_pkg::CREDIT_W,
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_change_valid,
  input  logic [CREDIT_W_P-1:0] i_change_amt,
  output logic                  o_change_ready,
  input  logic                  i_hopper2_empty,
  input  logic                  i_hopper1_empty,
  input  logic                  i_coin_sensed,
  input  logic                  i_clear_fault,
  output logic                  o_eject2,
  output logic                  o_eject1,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fault,
  output logic [CREDIT_W_P-1:0] o_remaining
);

  // One timer serves PULSE, GAP and WAIT_ACK, so size it for the longest.
  localparam int MAX_CYC = max3(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  // Timer reload values: the timer reads zero on the last cycle of a phase.
  localparam logic [TMR_W-1:0] L_PULSE   = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] L_GAP     = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] L_TIMEOUT = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [CREDIT_W_P-1:0] L_DENOM_HI = CREDIT_W_P'(DENOM_HI);
  localparam logic [CREDIT_W_P-1:0] L_DENOM_LO = CREDIT_W_P'(DENOM_LO);

  disp_state_t           r_state;
  disp_state_t           w_state_next;
  logic [CREDIT_W_P-1:0] r_remaining;
  logic [CREDIT_W_P-1:0] w_remaining_next;
  logic                  r_denom_hi;
  logic                  w_denom_hi_next;
  logic                  r_sensed;
  logic                  w_sensed_next;
  logic                  r_eject2;
  logic                  r_eject1;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fault;
  logic                  r_ready;
  logic [CREDIT_W_P-1:0] w_denom;
  logic                  w_tmr_load;
  logic [TMR_W-1:0]      w_tmr_val;
  logic                  w_tmr_zero;

  vend_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  assign w_denom = r_denom_hi ? L_DENOM_HI : L_DENOM_LO;

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_denom_hi  <= 1'b0;
      r_sensed    <= 1'b0;
      r_eject2    <= 1'b0;
      r_eject1    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_denom_hi  <= w_denom_hi_next;
      r_sensed    <= w_sensed_next;
      r_eject2    <= (w_state_next == ST_PULSE) && w_denom_hi_next;
      r_eject1    <= (w_state_next == ST_PULSE) && !w_denom_hi_next;
      r_busy      <= (w_state_next != ST_IDLE) && (w_state_next != ST_FAULT);
      r_done      <= (w_state_next == ST_DONE);
      r_fault     <= (w_state_next == ST_FAULT);
      r_ready     <= (w_state_next == ST_IDLE);
    end
  end

  // Next-state, coin accounting and timer control.
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_denom_hi_next  = r_denom_hi;
    w_sensed_next    = r_sensed;
    w_tmr_load       = 1'b0;
    w_tmr_val        = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_change_valid) begin
          w_remaining_next = i_change_amt;
          w_state_next     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        // Greedy: prefer the large coin, fall back to the small one.
        if (r_remaining == '0) begin
          w_state_next = ST_DONE;
        end else if ((r_remaining >= L_DENOM_HI) && !i_hopper2_empty) begin
          w_denom_hi_next = 1'b1;
          w_sensed_next   = 1'b0;
          w_tmr_load      = 1'b1;
          w_tmr_val       = L_PULSE;
          w_state_next    = ST_PULSE;
        end else if (!i_hopper1_empty) begin
          w_denom_hi_next = 1'b0;
          w_sensed_next   = 1'b0;
          w_tmr_load      = 1'b1;
          w_tmr_val       = L_PULSE;
          w_state_next    = ST_PULSE;
        end else begin
          w_state_next = ST_FAULT;
        end
      end
      ST_PULSE: begin
        // An early sense is remembered; the pulse always runs full length.
        if (i_coin_sensed) begin
          w_sensed_next = 1'b1;
        end
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          if (r_sensed || i_coin_sensed) begin
            w_remaining_next = r_remaining - w_denom;
            w_tmr_val        = L_GAP;
            w_state_next     = ST_GAP;
          end else begin
            w_tmr_val    = L_TIMEOUT;
            w_state_next = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        // A sense on the expiry cycle still counts as a coin.
        if (i_coin_sensed) begin
          w_remaining_next = r_remaining - w_denom;
          w_tmr_load       = 1'b1;
          w_tmr_val        = L_GAP;
          w_state_next     = ST_GAP;
        end else if (w_tmr_zero) begin
          w_state_next = ST_FAULT;
        end
      end
      ST_GAP: begin
        if (w_tmr_zero) begin
          w_state_next = ST_SELECT;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      ST_FAULT: begin
        // Remaining holds the shortfall until the operator acknowledges.
        if (i_clear_fault) begin
          w_remaining_next = '0;
          w_state_next     = ST_IDLE;
        end
      end
      default: begin
        w_remaining_next = '0;
        w_state_next     = ST_IDLE;
      end
    endcase
  end

  assign o_change_ready = r_ready;
  assign o_eject2       = r_eject2;
  assign o_eject1       = r_eject1;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_fault        = r_fault;
  assign o_remaining    = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: scenario tasks with a
// scoreboard of expected transaction outcomes and a coin-sensor responder.
module tb_change_dispenser;

  logic       clk;
  logic       rst;
  logic       change_valid;
  logic [3:0] change_amt;
  logic       change_ready;
  logic       hopper2_empty;
  logic       hopper1_empty;
  logic       coin_sensed;
  logic       clear_fault;
  logic       eject2;
  logic       eject1;
  logic       busy;
  logic       done;
  logic       fault;
  logic [3:0] remaining;

  int tests_run;
  int tests_failed;

  // Responder mode: 0 never sense, 1 sense one cycle after the pulse,
  // 2 sense during the second pulse cycle.
  int mode;
  int pcnt;
  bit prev_ej;

  // Monitor state.
  int n2, n1, w2, w1, width_err, overlap_err;
  logic [3:0] prev_rem;
  logic [3:0] rem_log[$];

  typedef struct {
    bit         is_done;
    logic [3:0] rem;
    int         n2;
    int         n1;
    int         lat;
  } exp_t;
  exp_t sb[$];

  change_dispenser #(
    .CREDIT_W_P     (4),
    .PULSE_CYCLES   (4),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_change_valid  (change_valid),
    .i_change_amt    (change_amt),
    .o_change_ready  (change_ready),
    .i_hopper2_empty (hopper2_empty),
    .i_hopper1_empty (hopper1_empty),
    .i_coin_sensed   (coin_sensed),
    .i_clear_fault   (clear_fault),
    .o_eject2        (eject2),
    .o_eject1        (eject1),
    .o_busy          (busy),
    .o_done          (done),
    .o_fault         (fault),
    .o_remaining     (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exit-sensor model.
  initial begin
    coin_sensed = 1'b0;
    pcnt        = 0;
    prev_ej     = 1'b0;
    forever begin
      @(negedge clk);
      coin_sensed = 1'b0;
      if (mode == 1 && prev_ej && !(eject2 || eject1)) coin_sensed = 1'b1;
      if (mode == 2) begin
        if (eject2 || eject1) pcnt++;
        else pcnt = 0;
        if (pcnt == 2) coin_sensed = 1'b1;
      end
      prev_ej = eject2 || eject1;
    end
  end

  // Pulse counter / width and overlap monitor, plus remaining-value log.
  always @(negedge clk) begin
    if (eject2 && eject1) overlap_err++;
    if (eject2) w2++;
    else if (w2 != 0) begin
      n2++;
      if (w2 != 4) width_err++;
      w2 = 0;
    end
    if (eject1) w1++;
    else if (w1 != 0) begin
      n1++;
      if (w1 != 4) width_err++;
      w1 = 0;
    end
    if (remaining !== prev_rem) begin
      rem_log.push_back(remaining);
      prev_rem = remaining;
    end
  end

  function automatic string fmt_log();
    string s;
    s = "";
    foreach (rem_log[k]) s = (k == 0) ? $sformatf("%0d", rem_log[k]) : $sformatf("%s,%0d", s, rem_log[k]);
    return s;
  endfunction

  // Drive one request and score its outcome against the expected entry.
  task automatic run_txn(input logic [3:0] amt, input bit h2e, input bit h1e, input int md,
                         input bit exp_done, input logic [3:0] exp_rem,
                         input int e2, input int e1, input int elat);
    exp_t e;
    exp_t ex;
    int   cyc;
    bit   got;
    bit   obs_done;
    logic [3:0] obs_rem;
    e.is_done = exp_done; e.rem = exp_rem; e.n2 = e2; e.n1 = e1; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    hopper2_empty = h2e; hopper1_empty = h1e; mode = md;
    n2 = 0; n1 = 0; w2 = 0; w1 = 0; width_err = 0; overlap_err = 0;
    rem_log.delete(); prev_rem = remaining;
    tests_run++;
    if (change_ready !== 1'b1) begin
      tests_failed++; $display("FAIL ready_before_req: got %b want 1", change_ready);
    end
    change_valid = 1'b1; change_amt = amt;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    change_valid = 1'b0;
    got = 1'b0; obs_done = 1'b0; obs_rem = '0;
    while (!got && cyc < 200) begin
      @(posedge clk); cyc++; #1;
      if (done || fault) begin
        got = 1'b1; obs_done = done; obs_rem = remaining;
      end
    end
    ex = sb.pop_front();
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL txn_timeout amt=%0d: no done/fault within %0d cycles", amt, cyc);
    end else begin
      $display("[TB] txn amt=%0d %s rem=%0d n2=%0d n1=%0d lat=%0d", amt,
               obs_done ? "done" : "fault", obs_rem, n2, n1, cyc);
      tests_run += 6;
      if (obs_done !== ex.is_done) begin tests_failed++; $display("FAIL outcome_done: got %b want %b", obs_done, ex.is_done); end
      if (obs_rem !== ex.rem) begin tests_failed++; $display("FAIL final_remaining: got %0d want %0d", obs_rem, ex.rem); end
      if (n2 != ex.n2) begin tests_failed++; $display("FAIL eject2_count: got %0d want %0d", n2, ex.n2); end
      if (n1 != ex.n1) begin tests_failed++; $display("FAIL eject1_count: got %0d want %0d", n1, ex.n1); end
      if (cyc != ex.lat) begin tests_failed++; $display("FAIL latency: got %0d want %0d", cyc, ex.lat); end
      if (width_err != 0 || overlap_err != 0) begin
        tests_failed++; $display("FAIL pulse_shape: width_err=%0d overlap_err=%0d want 0/0", width_err, overlap_err);
      end
      if (ex.is_done) begin
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || change_ready !== 1'b1) begin
          tests_failed++; $display("FAIL done_one_cycle: done=%b ready=%b want 0/1", done, change_ready);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    tests_run++;
    if (change_ready !== 1'b1 || eject2 !== 1'b0 || eject1 !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || fault !== 1'b0 || remaining !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b e2=%b e1=%b busy=%b done=%b fault=%b rem=%0d want 1/0/0/0/0/0/0",
               change_ready, eject2, eject1, busy, done, fault, remaining);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_greedy();
    run_txn(4'd3, 1'b0, 1'b0, 1, 1'b1, 4'd0, 1, 1, 18);
    tests_run++;
    if (fmt_log() != "3,1,0") begin tests_failed++; $display("FAIL greedy_rem_seq: got %s want 3,1,0", fmt_log()); end
  endtask

  task automatic test_zero_amt();
    run_txn(4'd0, 1'b0, 1'b0, 1, 1'b1, 4'd0, 0, 0, 2);
    tests_run++;
    if (rem_log.size() != 0) begin tests_failed++; $display("FAIL zero_rem_seq: got %s want empty", fmt_log()); end
  endtask

  task automatic test_hopper2_empty();
    run_txn(4'd4, 1'b1, 1'b0, 1, 1'b1, 4'd0, 0, 4, 34);
    tests_run++;
    if (fmt_log() != "4,3,2,1,0") begin tests_failed++; $display("FAIL h2empty_rem_seq: got %s want 4,3,2,1,0", fmt_log()); end
  endtask

  task automatic test_timeout_fault();
    run_txn(4'd2, 1'b0, 1'b0, 0, 1'b0, 4'd2, 1, 0, 22);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (fault !== 1'b1 || remaining !== 4'd2 || busy !== 1'b0 || change_ready !== 1'b0) begin
      tests_failed++; $display("FAIL fault_sticky: fault=%b rem=%0d busy=%b ready=%b want 1/2/0/0", fault, remaining, busy, change_ready);
    end
    @(negedge clk); clear_fault = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (fault !== 1'b0 || change_ready !== 1'b1 || remaining !== 4'd0) begin
      tests_failed++; $display("FAIL clear_fault: fault=%b ready=%b rem=%0d want 0/1/0", fault, change_ready, remaining);
    end
    @(negedge clk); clear_fault = 1'b0;
  endtask

  task automatic test_hopper1_empty_fault();
    run_txn(4'd1, 1'b0, 1'b1, 1, 1'b0, 4'd1, 0, 0, 2);
    @(negedge clk); clear_fault = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (fault !== 1'b0 || change_ready !== 1'b1) begin
      tests_failed++; $display("FAIL clear_fault2: fault=%b ready=%b want 0/1", fault, change_ready);
    end
    @(negedge clk); clear_fault = 1'b0; hopper1_empty = 1'b0;
  endtask

  task automatic test_async_reset();
    int k;
    @(negedge clk);
    mode = 0; hopper2_empty = 1'b0; hopper1_empty = 1'b0;
    change_valid = 1'b1; change_amt = 4'd2;
    @(negedge clk); change_valid = 1'b0;
    k = 0;
    while (eject2 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    tests_run++;
    if (eject2 !== 1'b1) begin
      tests_failed++; $display("FAIL reset_setup: eject2 never rose");
    end else begin
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      tests_run++;
      if (eject2 !== 1'b0 || busy !== 1'b0 || remaining !== 4'd0 || change_ready !== 1'b1) begin
        tests_failed++; $display("FAIL async_reset: e2=%b busy=%b rem=%0d ready=%b want 0/0/0/1", eject2, busy, remaining, change_ready);
      end
    end
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(4'd1, 1'b0, 1'b0, 1, 1'b1, 4'd0, 0, 1, 10);
  endtask

  task automatic test_early_sense();
    run_txn(4'd1, 1'b0, 1'b0, 2, 1'b1, 4'd0, 0, 1, 9);
    tests_run++;
    if (fmt_log() != "1,0") begin tests_failed++; $display("FAIL early_rem_seq: got %s want 1,0", fmt_log()); end
    run_txn(4'd3, 1'b0, 1'b0, 2, 1'b1, 4'd0, 1, 1, 16);
  endtask

  task automatic test_back_to_back();
    run_txn(4'd2, 1'b0, 1'b0, 1, 1'b1, 4'd0, 1, 0, 10);
    run_txn(4'd5, 1'b0, 1'b0, 1, 1'b1, 4'd0, 2, 1, 26);
    tests_run++;
    if (fmt_log() != "5,3,1,0") begin tests_failed++; $display("FAIL b2b_rem_seq: got %s want 5,3,1,0", fmt_log()); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    mode = 0; n2 = 0; n1 = 0; w2 = 0; w1 = 0; width_err = 0; overlap_err = 0;
    prev_rem = '0;
    change_valid = 1'b0; change_amt = '0;
    hopper2_empty = 1'b0; hopper1_empty = 1'b0; clear_fault = 1'b0;
    test_reset();
    test_greedy();
    test_zero_amt();
    test_hopper2_empty();
    test_timeout_fault();
    test_hopper1_empty_fault();
    test_async_reset();
    test_early_sense();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
